// File: rtl/ssds_mux_bus_interface.sv
`default_nettype none
// ============================================================================
// Module   : ssds_mux_bus_interface
// Brief    : Memory-mapped, time-multiplexed seven-segment display controller
//            with PWM brightness, per-digit blink and a scan status register.
// Revision : 1.0 - initial release
// ============================================================================
module ssds_mux_bus_interface #(
    parameter logic [31:0] START_ADDR = 32'h0,
    parameter int          DIGITS     = 8,
    parameter int          SCAN_DIV   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic [6:0]        ctrl_seg,
    output logic              ctrl_dot,
    output logic [DIGITS-1:0] ctrl_digit_en,
    input  logic [31:0]       addr_bus,
    inout  wire  [31:0]       data_bus,
    input  logic              rd_bus,
    input  logic              wr_bus,
    input  logic [3:0]        data_mask_bus,
    output wire               fc_bus
);

    localparam int          c_pw         = $clog2(SCAN_DIV);
    localparam int          c_slot       = SCAN_DIV / 16;
    localparam logic [7:0]  c_digit_mask = 8'((1 << DIGITS) - 1);
    localparam logic [2:0]  c_last_digit = 3'(DIGITS - 1);

    // Bus decode
    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rdata;

    assign w_hit = (addr_bus[31:5] == START_ADDR[31:5]);
    assign w_idx = addr_bus[4:2];
    assign w_wr  = w_hit & wr_bus;
    assign w_rd  = w_hit & rd_bus;

    // Register file
    logic        r_enable;
    logic [3:0]  r_bright;
    logic [7:0]  r_dots;
    logic [7:0]  r_bmask;
    logic [15:0] r_bperiod;
    logic        r_wr_flag;
    logic [7:0]  w_digit_byte [0:7];

    // Scan and blink state
    logic [c_pw-1:0] r_presc;
    logic [2:0]      r_digit;
    logic [15:0]     r_fcount;
    logic            r_phase;
    logic            w_presc_wrap;
    logic            w_frame_tick;

    // Digit code storage; slots beyond DIGITS are constant zero so their
    // writes are dropped and reads return 0.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < DIGITS) begin : g_used
                localparam int         c_lane = gi % 4;
                localparam logic [2:0] c_reg  = (gi < 4) ? 3'd1 : 3'd2;
                logic [7:0] r_byte;
                // Byte-lane write of this digit's code
                always_ff @(posedge clk) begin
                    if (rst)
                        r_byte <= 8'h00;
                    else if (w_wr && (w_idx == c_reg) && data_mask_bus[c_lane])
                        r_byte <= data_bus[8*c_lane +: 8];
                end
                assign w_digit_byte[gi] = r_byte;
            end else begin : g_unused
                assign w_digit_byte[gi] = 8'h00;
            end
        end
    endgenerate

    // Control, dot/blink-mask and blink-period registers with byte lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable  <= 1'b0;
            r_bright  <= 4'hF;
            r_dots    <= 8'h00;
            r_bmask   <= 8'h00;
            r_bperiod <= 16'h0000;
        end else if (w_wr) begin
            case (w_idx)
                3'd0: begin
                    if (data_mask_bus[0]) r_enable <= data_bus[0];
                    if (data_mask_bus[1]) r_bright <= data_bus[11:8];
                end
                3'd3: begin
                    if (data_mask_bus[0]) r_dots  <= data_bus[7:0] & c_digit_mask;
                    if (data_mask_bus[1]) r_bmask <= data_bus[15:8] & c_digit_mask;
                end
                3'd4: begin
                    if (data_mask_bus[0]) r_bperiod[7:0]  <= data_bus[7:0];
                    if (data_mask_bus[1]) r_bperiod[15:8] <= data_bus[15:8];
                end
                default: ;
            endcase
        end
    end

    // Write-acknowledge flag: set by every edge that sees a write strobe
    always_ff @(posedge clk) begin
        if (rst) r_wr_flag <= 1'b0;
        else     r_wr_flag <= w_wr;
    end

    // Read-back multiplexer
    always_comb begin
        w_rdata = 32'h0;
        case (w_idx)
            3'd0: w_rdata = {20'h0, r_bright, 7'h0, r_enable};
            3'd1: w_rdata = {w_digit_byte[3], w_digit_byte[2], w_digit_byte[1], w_digit_byte[0]};
            3'd2: w_rdata = {w_digit_byte[7], w_digit_byte[6], w_digit_byte[5], w_digit_byte[4]};
            3'd3: w_rdata = {16'h0, r_bmask, r_dots};
            3'd4: w_rdata = {16'h0, r_bperiod};
            3'd5: w_rdata = {23'h0, r_phase, 5'h0, r_digit};
            default: w_rdata = 32'h0;
        endcase
    end

    assign data_bus = w_rd ? w_rdata : 32'hzzzz_zzzz;
    assign fc_bus   = w_hit ? (rd_bus | (r_wr_flag & wr_bus)) : 1'bz;

    assign w_presc_wrap = (r_presc == c_pw'(SCAN_DIV - 1));
    assign w_frame_tick = w_presc_wrap && (r_digit == c_last_digit);

    // Free-running prescaler and digit scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= 3'd0;
        end else begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
            if (w_presc_wrap)
                r_digit <= (r_digit == c_last_digit) ? 3'd0 : r_digit + 3'd1;
        end
    end

    // Blink frame counter and phase; a period write restarts the pattern
    always_ff @(posedge clk) begin
        if (rst || (w_wr && (w_idx == 3'd4)) || (r_bperiod == 16'h0)) begin
            r_fcount <= 16'h0;
            r_phase  <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_fcount == r_bperiod - 16'd1) begin
                r_fcount <= 16'h0;
                r_phase  <= ~r_phase;
            end else begin
                r_fcount <= r_fcount + 16'd1;
            end
        end
    end

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 7'h3F; 4'h1: f_hex = 7'h06; 4'h2: f_hex = 7'h5B; 4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66; 4'h5: f_hex = 7'h6D; 4'h6: f_hex = 7'h7D; 4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F; 4'h9: f_hex = 7'h6F; 4'hA: f_hex = 7'h77; 4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39; 4'hD: f_hex = 7'h5E; 4'hE: f_hex = 7'h79; default: f_hex = 7'h71;
        endcase
    endfunction

    // Display path
    logic [c_pw:0]     w_on_limit;
    logic              w_lit;
    logic [7:0]        w_cur_byte;
    logic [6:0]        w_seg_dec;
    logic [DIGITS-1:0] w_onehot;

    assign w_on_limit = (c_pw+1)'((32'(r_bright) + 32'd1) * 32'(c_slot));
    assign w_lit      = r_enable && ({1'b0, r_presc} < w_on_limit) &&
                        !(r_phase && r_bmask[r_digit]);
    assign w_cur_byte = w_digit_byte[r_digit];
    assign w_seg_dec  = w_cur_byte[7] ? f_hex(w_cur_byte[3:0]) : w_cur_byte[6:0];
    assign w_onehot   = DIGITS'(1) << r_digit;

    // Registered pin drivers; blanked digits drive everything low
    always_ff @(posedge clk) begin
        if (rst || !w_lit) begin
            ctrl_seg      <= 7'h00;
            ctrl_dot      <= 1'b0;
            ctrl_digit_en <= '0;
        end else begin
            ctrl_seg      <= w_seg_dec;
            ctrl_dot      <= r_dots[r_digit];
            ctrl_digit_en <= w_onehot;
        end
    end

endmodule
`default_nettype wire
